// File: rtl/weight_stream_tx_pkg.sv
// Shared definitions for the weight stream transmitter.
//   state_t   : replay FSM state encoding (IDLE / STREAM / DRAIN / DONE).
//   clog2     : ceiling log2 for elaboration-time width calculation.
//   sel_width : index width for a table of n entries, never below 1 bit.
package weight_stream_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  function automatic int sel_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_stream_ram.sv
// Weight storage: DEPTH x DATA_WIDTH memory, one write port and one
// registered read port (one cycle read latency), shaped for block RAM.
//   clk        : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_en_i    : read strobe; rd_data_o updates only when set
//   rd_addr_i  : read address
//   rd_data_o  : registered read data
module weight_stream_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/weight_stream_tx.sv
// Weight stream transmitter. Holds a block of weights loaded by a host plus a
// per-port segment-length table; on start, replays segment p to port p, one
// word per cycle, on a shared bus with a one-hot per-port valid.
//   clk              : clock, rising edge
//   reset            : synchronous, active-low
//   wr_en/wr_addr/wr_data    : host RAM write (honoured only when idle)
//   len_we/len_sel/len_data  : length-table write (honoured only when idle)
//   start            : begin a replay (honoured only when idle)
//   pause            : hold off issuing reads while high
//   valid_weight_out : per-port valid, one-hot or zero
//   weight_out       : shared weight bus, holds last word between valids
//   busy             : replay in progress
//   done             : one-cycle completion pulse
module weight_stream_tx
  import weight_stream_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 13,
  localparam int SEL_WIDTH = sel_width(NUM_PORTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  len_we,
  input  logic [SEL_WIDTH-1:0]  len_sel,
  input  logic [LEN_WIDTH-1:0]  len_data,
  input  logic                  start,
  input  logic                  pause,
  output logic [NUM_PORTS-1:0]  valid_weight_out,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  busy,
  output logic                  done
);

  state_t                state_q;
  logic [LEN_WIDTH-1:0]  len_q [NUM_PORTS];
  logic [SEL_WIDTH-1:0]  seg_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  count_q;
  logic                  rd_valid_q;
  logic [SEL_WIDTH-1:0]  rd_tag_q;
  logic [NUM_PORTS-1:0]  valid_q;
  logic [DATA_WIDTH-1:0] weight_q;
  logic                  busy_q;
  logic                  done_q;

  logic [NUM_PORTS-1:0]  seg_live_d;
  logic                  cur_found_d;
  logic                  later_found_d;
  logic [SEL_WIDTH-1:0]  cur_seg_d;
  logic [LEN_WIDTH-1:0]  cur_len_d;
  logic [LEN_WIDTH-1:0]  count_inc_d;
  logic                  seg_end_d;
  logic                  issue_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_we_d;

  // A segment is a candidate if it is nonzero and not yet passed.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_live
    assign seg_live_d[gi] = (len_q[gi] != '0) && (gi >= int'(seg_q));
  end

  // The current segment is the first live one, so zero-length entries are
  // skipped in the same cycle; later_found_d tells whether more work remains.
  always_comb begin
    cur_found_d   = 1'b0;
    later_found_d = 1'b0;
    cur_seg_d     = seg_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (seg_live_d[p]) begin
        if (cur_found_d) begin
          later_found_d = 1'b1;
        end else begin
          cur_found_d = 1'b1;
          cur_seg_d   = SEL_WIDTH'(p);
        end
      end
    end
  end

  assign cur_len_d   = len_q[cur_seg_d];
  assign count_inc_d = count_q + LEN_WIDTH'(1);
  assign seg_end_d   = (count_inc_d == cur_len_d);
  assign issue_d     = (state_q == ST_STREAM) && cur_found_d && !pause;
  // Address arithmetic is ADDR_WIDTH wide, so it wraps modulo DEPTH.
  assign rd_addr_d   = base_q + count_q[ADDR_WIDTH-1:0];
  assign ram_we_d    = wr_en && (state_q == ST_IDLE);

  weight_stream_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk      (clk),
    .wr_en_i  (ram_we_d),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .rd_en_i  (issue_d),
    .rd_addr_i(rd_addr_d),
    .rd_data_o(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      seg_q      <= '0;
      base_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_tag_q   <= '0;
      valid_q    <= '0;
      weight_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        len_q[p] <= '0;
      end
    end else begin
      done_q     <= 1'b0;
      // Output stage: the RAM word read last cycle goes out with its tag.
      rd_valid_q <= issue_d;
      if (issue_d) begin
        rd_tag_q <= cur_seg_d;
      end
      valid_q <= rd_valid_q ? (NUM_PORTS'(1) << rd_tag_q) : '0;
      if (rd_valid_q) begin
        weight_q <= ram_rdata;
      end

      case (state_q)
        ST_IDLE: begin
          if (len_we) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
              if (len_sel == SEL_WIDTH'(p)) begin
                len_q[p] <= len_data;
              end
            end
          end
          if (start) begin
            state_q <= ST_STREAM;
            seg_q   <= '0;
            base_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (!cur_found_d) begin
            // Only reachable when every length is zero.
            state_q <= ST_DONE;
          end else if (!pause) begin
            if (seg_end_d) begin
              base_q  <= base_q + cur_len_d[ADDR_WIDTH-1:0];
              count_q <= '0;
              if (later_found_d) begin
                seg_q <= cur_seg_d + SEL_WIDTH'(1);
              end else begin
                state_q <= ST_DRAIN;
              end
            end else begin
              seg_q   <= cur_seg_d;
              count_q <= count_inc_d;
            end
          end
        end
        ST_DRAIN: begin
          // The final word reaches the output register on this edge.
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign valid_weight_out = valid_q;
  assign weight_out       = weight_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_weight_stream_tx.sv
// Self-checking bench for weight_stream_tx. A reference model turns the
// length table, RAM image and pause schedule into the per-cycle outputs
// expected after the start edge (cycle 0).
module tb_weight_stream_tx;

  localparam int DW    = 32;
  localparam int NP    = 4;
  localparam int AW    = 12;
  localparam int LW    = 13;
  localparam int DEPTH = 4096;
  localparam int MAXC  = 8192;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          len_we;
  logic [1:0]    len_sel;
  logic [LW-1:0] len_data;
  logic          start;
  logic          pause;
  logic [NP-1:0] valid_weight_out;
  logic [DW-1:0] weight_out;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_ram [DEPTH];
  int            m_len [NP];
  bit            m_pause [MAXC];
  logic [NP-1:0] exp_v [MAXC];
  logic [DW-1:0] exp_w [MAXC];
  int            exp_done;
  int            exp_words;

  logic [NP-1:0] obs_v [MAXC];
  logic [DW-1:0] obs_w [MAXC];
  logic          obs_b [MAXC];
  logic          obs_d [MAXC];
  int            n_obs;

  weight_stream_tx dut (
    .clk             (clk),
    .reset           (reset),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .len_we          (len_we),
    .len_sel         (len_sel),
    .len_data        (len_data),
    .start           (start),
    .pause           (pause),
    .valid_weight_out(valid_weight_out),
    .weight_out      (weight_out),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic write_ram(input int addr, input logic [DW-1:0] data);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    m_ram[addr] = data;
  endtask

  task automatic set_lens(input int l0, input int l1, input int l2, input int l3);
    int l [NP];
    l = '{l0, l1, l2, l3};
    for (int p = 0; p < NP; p++) begin
      len_we = 1'b1; len_sel = 2'(p); len_data = LW'(l[p]);
      @(posedge clk); #1;
      len_we = 1'b0;
      m_len[p] = l[p];
    end
  endtask

  task automatic clear_pause();
    for (int c = 0; c < MAXC; c++) m_pause[c] = 1'b0;
  endtask

  // Reference model: flatten segments into an ordered word list, then place
  // word j on the j-th unpaused issue edge (>= 1); it appears one cycle later.
  task automatic build_expect();
    int ports[$];
    logic [DW-1:0] words[$];
    int base = 0;
    int k = 1;
    int last = 0;
    for (int c = 0; c < MAXC; c++) begin
      exp_v[c] = '0;
      exp_w[c] = '0;
    end
    for (int p = 0; p < NP; p++) begin
      for (int i = 0; i < m_len[p]; i++) begin
        ports.push_back(p);
        words.push_back(m_ram[(base + i) % DEPTH]);
      end
      base += m_len[p];
    end
    for (int j = 0; j < ports.size(); j++) begin
      while (m_pause[k]) k++;
      exp_v[k + 1] = NP'(1) << ports[j];
      exp_w[k + 1] = words[j];
      last = k;
      k++;
    end
    exp_words = ports.size();
    exp_done  = (exp_words == 0) ? 2 : last + 2;
  endtask

  // Pulses start, then records outputs for each cycle after the start edge.
  // inject_cyc: edge at which start/wr_en/len_we are asserted mid-replay.
  // abort_cyc : edge at which reset is asserted for one cycle.
  task automatic run_replay(input string name, input int inject_cyc, input int abort_cyc);
    n_obs = (abort_cyc >= 0) ? abort_cyc + 10 : exp_done + 3;
    start = 1'b1; pause = 1'b0;
    for (int c = 0; c < n_obs; c++) begin
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0; len_we = 1'b0; reset = 1'b1;
      obs_v[c] = valid_weight_out;
      obs_w[c] = weight_out;
      obs_b[c] = busy;
      obs_d[c] = done;
      pause = m_pause[c + 1];
      if (c + 1 == inject_cyc) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 99;
        len_we = 1'b1; len_sel = 2'd0; len_data = 5;
      end
      if (c + 1 == abort_cyc) reset = 1'b0;
    end
    pause = 1'b0;
    $display("replay %s words=%0d done_cyc=%0d cycles=%0d", name, exp_words, exp_done, n_obs);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (valid_weight_out !== '0 || weight_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL reset cyc=%0d got valid=%b word=%0d busy=%b done=%b, required all 0",
                 c, valid_weight_out, weight_out, busy, done);
      end
    end
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (valid_weight_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got valid=%b busy=%b done=%b, required 0 0 0",
               valid_weight_out, busy, done);
    end
  endtask

  task automatic test_basic();
    for (int a = 0; a < 6; a++) write_ram(a, DW'(10 + a));
    set_lens(2, 1, 3, 0);
    clear_pause();
    build_expect();
    run_replay("basic", -1, -1);
    for (int c = 0; c < n_obs; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || obs_b[c] !== (c < exp_done) || obs_d[c] !== (c == exp_done) ||
          (exp_v[c] != '0 && obs_w[c] !== exp_w[c])) begin
        failures++;
        $display("FAIL basic cyc=%0d got valid=%b word=%0d busy=%b done=%b, required valid=%b word=%0d busy=%b done=%b",
                 c, obs_v[c], obs_w[c], obs_b[c], obs_d[c], exp_v[c], exp_w[c], c < exp_done, c == exp_done);
      end
    end
  endtask

  task automatic test_pause();
    clear_pause();
    m_pause[3] = 1'b1;
    m_pause[4] = 1'b1;
    build_expect();
    run_replay("pause", -1, -1);
    for (int c = 0; c < n_obs; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || obs_b[c] !== (c < exp_done) || obs_d[c] !== (c == exp_done) ||
          (exp_v[c] != '0 && obs_w[c] !== exp_w[c])) begin
        failures++;
        $display("FAIL pause cyc=%0d got valid=%b word=%0d busy=%b done=%b, required valid=%b word=%0d busy=%b done=%b",
                 c, obs_v[c], obs_w[c], obs_b[c], obs_d[c], exp_v[c], exp_w[c], c < exp_done, c == exp_done);
      end
    end
    clear_pause();
  endtask

  task automatic test_zero_segments();
    for (int a = 0; a < 4; a++) write_ram(a, DW'(7 + a));
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) set_lens(0, 0, 0, 4);
      else           set_lens(0, 0, 0, 0);
      build_expect();
      run_replay(pass == 0 ? "zero_skip" : "all_zero", -1, -1);
      for (int c = 0; c < n_obs; c++) begin
        checks++;
        if (obs_v[c] !== exp_v[c] || obs_b[c] !== (c < exp_done) || obs_d[c] !== (c == exp_done) ||
            (exp_v[c] != '0 && obs_w[c] !== exp_w[c])) begin
          failures++;
          $display("FAIL zero_seg pass=%0d cyc=%0d got valid=%b word=%0d busy=%b done=%b, required valid=%b word=%0d busy=%b done=%b",
                   pass, c, obs_v[c], obs_w[c], obs_b[c], obs_d[c], exp_v[c], exp_w[c], c < exp_done, c == exp_done);
        end
      end
    end
  endtask

  task automatic test_ignored_inputs();
    for (int a = 0; a < 6; a++) write_ram(a, DW'(10 + a));
    set_lens(2, 1, 3, 0);
    // First replay has start/wr_en/len_we injected mid-stream; the model
    // state is untouched, so the second replay must match the original too.
    for (int pass = 0; pass < 2; pass++) begin
      build_expect();
      run_replay(pass == 0 ? "ignored_inject" : "ignored_after", pass == 0 ? 3 : -1, -1);
      for (int c = 0; c < n_obs; c++) begin
        checks++;
        if (obs_v[c] !== exp_v[c] || obs_b[c] !== (c < exp_done) || obs_d[c] !== (c == exp_done) ||
            (exp_v[c] != '0 && obs_w[c] !== exp_w[c])) begin
          failures++;
          $display("FAIL ignored pass=%0d cyc=%0d got valid=%b word=%0d busy=%b done=%b, required valid=%b word=%0d busy=%b done=%b",
                   pass, c, obs_v[c], obs_w[c], obs_b[c], obs_d[c], exp_v[c], exp_w[c], c < exp_done, c == exp_done);
        end
      end
    end
  endtask

  task automatic test_abort();
    build_expect();
    run_replay("abort", -1, 4);
    for (int c = 0; c < n_obs; c++) begin
      if (c < 4) begin
        checks++;
        if (obs_v[c] !== exp_v[c] || obs_b[c] !== 1'b1 || obs_d[c] !== 1'b0 ||
            (exp_v[c] != '0 && obs_w[c] !== exp_w[c])) begin
          failures++;
          $display("FAIL abort_pre cyc=%0d got valid=%b word=%0d busy=%b done=%b, required valid=%b word=%0d busy=1 done=0",
                   c, obs_v[c], obs_w[c], obs_b[c], obs_d[c], exp_v[c], exp_w[c]);
        end
      end else if (c > 4) begin
        checks++;
        if (obs_v[c] !== '0 || obs_b[c] !== 1'b0 || obs_d[c] !== 1'b0) begin
          failures++;
          $display("FAIL abort_post cyc=%0d got valid=%b busy=%b done=%b, required 0 0 0",
                   c, obs_v[c], obs_b[c], obs_d[c]);
        end
      end
    end
    for (int p = 0; p < NP; p++) m_len[p] = 0;
    set_lens(2, 1, 3, 0);
    build_expect();
    run_replay("after_abort", -1, -1);
    for (int c = 0; c < n_obs; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || obs_b[c] !== (c < exp_done) || obs_d[c] !== (c == exp_done) ||
          (exp_v[c] != '0 && obs_w[c] !== exp_w[c])) begin
        failures++;
        $display("FAIL after_abort cyc=%0d got valid=%b word=%0d busy=%b done=%b, required valid=%b word=%0d busy=%b done=%b",
                 c, obs_v[c], obs_w[c], obs_b[c], obs_d[c], exp_v[c], exp_w[c], c < exp_done, c == exp_done);
      end
    end
  endtask

  // Full-depth segment followed by a short one that wraps back to address 0.
  task automatic test_wrap_full_depth();
    for (int a = 0; a < DEPTH; a++) write_ram(a, $urandom);
    set_lens(DEPTH, 0, 0, 3);
    build_expect();
    run_replay("wrap", -1, -1);
    for (int c = 0; c < n_obs; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || obs_b[c] !== (c < exp_done) || obs_d[c] !== (c == exp_done) ||
          (exp_v[c] != '0 && obs_w[c] !== exp_w[c])) begin
        failures++;
        $display("FAIL wrap cyc=%0d got valid=%b word=%0d busy=%b done=%b, required valid=%b word=%0d busy=%b done=%b",
                 c, obs_v[c], obs_w[c], obs_b[c], obs_d[c], exp_v[c], exp_w[c], c < exp_done, c == exp_done);
      end
    end
  endtask

  task automatic test_random();
    int l [NP];
    int total;
    for (int it = 0; it < 12; it++) begin
      total = 0;
      for (int p = 0; p < NP; p++) begin
        l[p] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6));
        total += l[p];
      end
      for (int a = 0; a < total; a++) write_ram(a, $urandom);
      set_lens(l[0], l[1], l[2], l[3]);
      clear_pause();
      for (int c = 1; c < 64; c++) m_pause[c] = ($urandom_range(0, 3) == 0);
      build_expect();
      run_replay("random", -1, -1);
      for (int c = 0; c < n_obs; c++) begin
        checks++;
        if (obs_v[c] !== exp_v[c] || obs_b[c] !== (c < exp_done) || obs_d[c] !== (c == exp_done) ||
            (exp_v[c] != '0 && obs_w[c] !== exp_w[c])) begin
          failures++;
          $display("FAIL random it=%0d cyc=%0d got valid=%b word=%0d busy=%b done=%b, required valid=%b word=%0d busy=%b done=%b",
                   it, c, obs_v[c], obs_w[c], obs_b[c], obs_d[c], exp_v[c], exp_w[c], c < exp_done, c == exp_done);
        end
      end
    end
    clear_pause();
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    len_we = 1'b0; len_sel = '0; len_data = '0; start = 1'b0; pause = 1'b0;
    for (int p = 0; p < NP; p++) m_len[p] = 0;
    clear_pause();
    #1;
    test_reset();
    test_basic();
    test_pause();
    test_zero_segments();
    test_ignored_inputs();
    test_abort();
    test_wrap_full_depth();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_stream_tx.md
Name: weight_stream_tx

Overview:
- Transmitter side of the valid/weight streaming interface consumed by the conv and identity blocks (valid_weight_inN/weight_inN).
- Holds a block of weights in on-chip RAM, loaded by a host write port, plus a per-port segment-length table.
- On a start pulse it replays segment 0 to port 0, segment 1 to port 1, and so on, one word per cycle.
- Sits between the weight loader and a resnet50 layer wrapper; one instance feeds NUM_PORTS weight inputs.

Parameters:
- DATA_WIDTH, 32, weight word width.
- NUM_PORTS, 4, number of weight streams driven (one per consumer weight port).
- ADDR_WIDTH, 12, RAM address width; DEPTH = 2**ADDR_WIDTH words.
- LEN_WIDTH, 13, width of a segment length (must hold DEPTH).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous active-low reset.
- wr_en  in  1  RAM write strobe.
- wr_addr  in  ADDR_WIDTH  RAM write address.
- wr_data  in  DATA_WIDTH  RAM write data.
- len_we  in  1  length-table write strobe.
- len_sel  in  clog2(NUM_PORTS)  length-table entry index.
- len_data  in  LEN_WIDTH  segment length for port len_sel.
- start  in  1  begin a replay (sampled in IDLE only).
- pause  in  1  suppress issuing new reads while high.
- valid_weight_out  out  NUM_PORTS  per-port valid; at most one bit set per cycle.
- weight_out  out  DATA_WIDTH  shared weight bus, meaningful only when a valid bit is set.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the replay completes.

Behaviour:
- Reset is synchronous and active-low. While reset = 0 at an edge:
  - valid_weight_out = 0, weight_out = 0, busy = 0, done = 0.
  - FSM goes to IDLE, length table cleared to 0.
  - RAM contents are not reset.
- Reset asserted mid-replay aborts it immediately, with no done pulse.
- FSM states:
  - IDLE: wait for start.
  - STREAM: issue reads.
  - DRAIN: the last read is in flight.
  - DONE: pulse done, then return to IDLE.
- IDLE -> STREAM on start = 1.
  - Segment pointer seg = 0, base = 0, count = 0.
  - busy = 1 from the next cycle.
- Segment base for port p = sum of len[0..p-1]. RAM addresses wrap modulo DEPTH.
- STREAM, each cycle with pause = 0:
  - Issue a read of RAM[base + count]; tag it with seg; count++.
  - When count reaches len[seg]: seg++, base += len[seg], count = 0.
- Zero-length segments are skipped with no idle cycle: seg advances to the next nonzero entry combinationally within the same cycle.
- Pause: a cycle with pause = 1 issues no read and leaves pointers unchanged. A read issued on the previous cycle still emerges normally.
- Read latency is 1 cycle. The word read at edge n appears on weight_out with valid_weight_out[tag] = 1 for the cycle after edge n+1. Earliest valid is 2 cycles after start is sampled.
- STREAM -> DRAIN after the last word of the last segment is issued.
- DRAIN -> DONE after that word is output. done = 1 for that one cycle, busy drops together with done, then IDLE.
- All lengths zero: STREAM -> DONE directly. done pulses 2 cycles after start, no valid ever asserted.
- start while busy: ignored.
- wr_en or len_we while busy: ignored, so the stream stays consistent.
- wr_en in IDLE writes the RAM at the edge; a read of the same address in a later replay returns the new data.
- valid_weight_out is one-hot or zero. weight_out holds its last value when no valid is set.

Decomposition:
- Shared package holds the FSM state encoding (IDLE/STREAM/DRAIN/DONE) and the clog2 helper function.
- One sub-module, weight_stream_ram: single-port write, single-port registered-read RAM of DEPTH x DATA_WIDTH, inferable as block RAM.
- FSM, length table and pointers live in the top.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with start = 1 -> all outputs 0, busy stays 0, no valid.
- Basic replay: RAM[0..5] = 10..15, len = {2,1,3,0}, pulse start at cycle 0.
  - Port 0 valid cycles 2–3 with 10, 11.
  - Port 1 valid cycle 4 with 12.
  - Port 2 valid cycles 5–7 with 13, 14, 15.
  - done at cycle 8; port 3 never valid.
- Pause: same load, pause = 1 for cycles 3–4 -> word 11 still appears at cycle 3. Remaining words shift 2 cycles later, done at cycle 10.
- Zero segments: len = {0,0,0,4}, RAM[0..3] = 7..10 -> only port 3 valid, cycles 2–5; done at 6. len all 0 -> done at 2, no valid.
- Ignored inputs: start and wr_en (addr 0, data 99) asserted mid-replay -> stream unchanged. The next replay still reads the original RAM[0].
- Abort: reset = 0 at cycle 4 of the basic replay -> valid/busy low from cycle 5, no done pulse. After reset release, reload lengths and start -> correct full replay.
